// File: rtl/sr_seq_muldiv.sv
// Iterative radix-2 unsigned multiplier/divider with a start/busy/done stall handshake.
// One result bit per cycle; optional pad cycles model slower units.
module sr_seq_muldiv #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned EXTRA_LAT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StPad, StDone} state_t;

   state_t           stateQ, stateD;
   logic [CW-1:0]    cntQ, cntD;
   logic [3:0]       padQ, padD;
   logic [1:0]       opQ, opD;
   logic [WIDTH-1:0] opndQ, opndD;
   logic [WIDTH-1:0] hiQ, hiD;
   logic [WIDTH-1:0] loQ, loD;
   logic [WIDTH-1:0] resultQ, resultD;

   logic [WIDTH:0]   mulSum, divShift, divDiff;
   logic [WIDTH-1:0] hiStep, loStep;

   // hi/lo hold {product high, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
   always_comb begin
      mulSum   = {1'b0, hiQ} + (loQ[0] ? {1'b0, opndQ} : '0);
      divShift = {hiQ, loQ[WIDTH-1]};
      divDiff  = divShift - {1'b0, opndQ};
      if (opQ[1]) begin
         // divDiff[WIDTH] is the borrow: set when the shifted remainder is below the divisor
         hiStep = divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
         loStep = {loQ[WIDTH-2:0], ~divDiff[WIDTH]};
      end else begin
         hiStep = mulSum[WIDTH:1];
         loStep = {mulSum[0], loQ[WIDTH-1:1]};
      end
   end

   always_comb begin
      stateD  = stateQ;
      cntD    = cntQ;
      padD    = padQ;
      opD     = opQ;
      opndD   = opndQ;
      hiD     = hiQ;
      loD     = loQ;
      resultD = resultQ;
      unique case (stateQ)
         StIdle, StDone: begin
            if (start) begin
               stateD = StCalc;
               opD    = op;
               opndD  = op[1] ? srcB : srcA;
               loD    = op[1] ? srcA : srcB;
               hiD    = '0;
               cntD   = '0;
            end else begin
               stateD = StIdle;
            end
         end
         StCalc: begin
            hiD  = hiStep;
            loD  = loStep;
            cntD = cntQ + 1'b1;
            if (cntQ == CW'(WIDTH - 1)) begin
               // MULHU/REMU live in the hi half, MUL/DIVU in the lo half
               resultD = opQ[0] ? hiStep : loStep;
               padD    = '0;
               stateD  = (EXTRA_LAT == 0) ? StDone : StPad;
            end
         end
         StPad: begin
            padD = padQ + 1'b1;
            if (padQ == 4'(EXTRA_LAT - 1)) stateD = StDone;
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ  <= StIdle;
         cntQ    <= '0;
         padQ    <= '0;
         opQ     <= '0;
         opndQ   <= '0;
         hiQ     <= '0;
         loQ     <= '0;
         resultQ <= '0;
      end else begin
         stateQ  <= stateD;
         cntQ    <= cntD;
         padQ    <= padD;
         opQ     <= opD;
         opndQ   <= opndD;
         hiQ     <= hiD;
         loQ     <= loD;
         resultQ <= resultD;
      end
   end

   assign busy   = (stateQ == StCalc) || (stateQ == StPad);
   assign done   = (stateQ == StDone);
   assign result = resultQ;

endmodule

// File: tb/tb_sr_seq_muldiv.sv
// Directed bench for sr_seq_muldiv: a 32-bit zero-pad unit and an 8-bit unit with 3 pad cycles.
module tb_sr_seq_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        start32, start8;
   logic [1:0]  op32, op8;
   logic [31:0] a32, b32, res32;
   logic [7:0]  a8, b8, res8;
   logic        busy32, done32, busy8, done8;

   int nAssert = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   sr_seq_muldiv #(.WIDTH(32), .EXTRA_LAT(0)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .op(op32), .srcA(a32), .srcB(b32),
      .busy(busy32), .done(done32), .result(res32)
   );

   sr_seq_muldiv #(.WIDTH(8), .EXTRA_LAT(3)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .srcA(a8), .srcB(b8),
      .busy(busy8), .done(done8), .result(res8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input logic [31:0] exp);
      int n;
      start32 = 1'b1; op32 = o; a32 = a; b32 = b;
      tick();
      start32 = 1'b0;
      n = 0;
      while (busy32 && n < 100) begin
         n++;
         tick();
      end
      check({tag, "_busycyc"}, 32'(n), 32'd32);
      check({tag, "_done"}, {31'd0, done32}, 32'd1);
      check({tag, "_res"}, res32, exp);
      tick();
      check({tag, "_donepulse"}, {31'd0, done32}, 32'd0);
   endtask

   task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input string tag, input logic [7:0] exp);
      int n;
      start8 = 1'b1; op8 = o; a8 = a; b8 = b;
      tick();
      start8 = 1'b0;
      n = 0;
      while (busy8 && n < 100) begin
         n++;
         tick();
      end
      check({tag, "_busycyc"}, 32'(n), 32'd11);
      check({tag, "_done"}, {31'd0, done8}, 32'd1);
      check({tag, "_res"}, {24'd0, res8}, {24'd0, exp});
      tick();
   endtask

   initial begin
      int n;
      int dones;
      logic [1:0]  ro;
      logic [7:0]  ra, rb, rexp;
      logic [15:0] prod;

      rst = 1'b1;
      start32 = 1'b0; op32 = 2'd0; a32 = '0; b32 = '0;
      start8  = 1'b0; op8  = 2'd0; a8  = '0; b8  = '0;
      tick();
      tick();
      check("rst_busy", {31'd0, busy32}, 32'd0);
      check("rst_done", {31'd0, done32}, 32'd0);
      check("rst_result", res32, 32'd0);
      rst = 1'b0;
      tick();

      run32(2'd0, 32'd7, 32'd6, "mul_7x6", 32'd42);
      run32(2'd0, 32'h10000, 32'h10000, "mul_2p16sq", 32'd0);
      run32(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_max", 32'hFFFFFFFE);
      run32(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul_max", 32'h00000001);
      run32(2'd2, 32'd100, 32'd7, "divu_100_7", 32'd14);
      run32(2'd3, 32'd100, 32'd7, "remu_100_7", 32'd2);
      run32(2'd2, 32'd5, 32'd0, "divu_by0", 32'hFFFFFFFF);
      run32(2'd3, 32'd5, 32'd0, "remu_by0", 32'd5);
      run32(2'd2, 32'hFFFFFFFF, 32'd1, "divu_max_1", 32'hFFFFFFFF);

      // start and operand changes mid-CALC must not disturb the captured operation
      start32 = 1'b1; op32 = 2'd0; a32 = 32'd3; b32 = 32'd5;
      tick();
      start32 = 1'b0;
      repeat (4) tick();
      start32 = 1'b1; op32 = 2'd2; a32 = 32'd100; b32 = 32'd100;
      tick();
      tick();
      check("ign_busy", {31'd0, busy32}, 32'd1);
      check("ign_hold", res32, 32'hFFFFFFFF);
      start32 = 1'b0; a32 = '0; b32 = '0;
      n = 0;
      while (!done32 && n < 100) begin
         n++;
         tick();
      end
      check("ign_done", {31'd0, done32}, 32'd1);
      check("ign_res", res32, 32'd15);

      // back-to-back start while done is high
      start32 = 1'b1; op32 = 2'd0; a32 = 32'd9; b32 = 32'd9;
      tick();
      start32 = 1'b0;
      check("b2b_nogap", {31'd0, busy32}, 32'd1);
      check("b2b_done_low", {31'd0, done32}, 32'd0);
      n = 1;
      while (!done32 && n < 100) begin
         n++;
         tick();
      end
      check("b2b_spacing", 32'(n), 32'd33);
      check("b2b_res", res32, 32'd81);
      tick();
      check("b2b_idle", {30'd0, busy32, done32}, 32'd0);

      // reset in CALC cycle 10
      start32 = 1'b1; op32 = 2'd0; a32 = 32'd7; b32 = 32'd6;
      tick();
      start32 = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", {31'd0, busy32}, 32'd0);
      check("midrst_done", {31'd0, done32}, 32'd0);
      check("midrst_res", res32, 32'd0);
      dones = 0;
      repeat (40) begin
         if (done32) dones++;
         tick();
      end
      check("midrst_nodone", 32'(dones), 32'd0);
      run32(2'd0, 32'd7, 32'd6, "postrst_mul", 32'd42);

      // reset beats a simultaneous start
      rst = 1'b1; start32 = 1'b1;
      tick();
      rst = 1'b0; start32 = 1'b0;
      check("rststart_busy", {31'd0, busy32}, 32'd0);
      tick();
      check("rststart_busy2", {31'd0, busy32}, 32'd0);

      run8(2'd2, 8'd200, 8'd9, "w8_divu_200_9", 8'd22);
      for (int i = 0; i < 10; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = 8'($urandom_range(0, 255));
         rb = (i == 3) ? 8'd0 : 8'($urandom_range(0, 255));
         prod = {8'd0, ra} * {8'd0, rb};
         case (ro)
            2'd0:    rexp = prod[7:0];
            2'd1:    rexp = prod[15:8];
            2'd2:    rexp = (rb == 0) ? 8'hFF : ra / rb;
            default: rexp = (rb == 0) ? ra : ra % rb;
         endcase
         run8(ro, ra, rb, $sformatf("w8_rand%0d", i), rexp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
